// File: rtl/bitserial_weight_streamer.sv
// Bit-serial weight transmitter: job FIFO feeding an LSB-first shift streamer with first/last beat flags.
// Optional BSW_ZERO_SKIP_EN collapses an all-zero N-bit weight into a single flagged beat on ser_zero.
module bitserial_weight_streamer #(
  parameter int ACT_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACT_W-1:0] in_act,
  input  logic [7:0]       in_wgt,
  input  logic [1:0]       in_prec,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic [ACT_W-1:0] ser_act,
  output logic [2:0]       ser_idx,
  output logic             ser_first,
  output logic             ser_last
`ifdef BSW_ZERO_SKIP_EN
  ,
  output logic             ser_zero
`endif
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ACT_W + 10;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_q;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       idx_q, idx_d, last_q, last_d;
  logic [ACT_W-1:0] act_q, act_d;
`ifdef BSW_ZERO_SKIP_EN
  logic             zero_q, zero_d;
`endif

  logic             push, pop, empty;
  logic [ENT_W-1:0] head;
  logic [ACT_W-1:0] head_act;
  logic [7:0]       head_wgt, head_mask;
  logic [1:0]       head_prec;
  logic [2:0]       head_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends on registered state only, so ser_ready never reaches it combinationally
  assign in_ready = init_q && (cnt_q != CNT_W'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = in_valid && in_ready;

  assign ser_valid = (state_q == SHIFT);
  assign ser_bit   = ser_valid && sh_q[0];
  assign ser_act   = ser_valid ? act_q : '0;
  assign ser_idx   = ser_valid ? idx_q : '0;
  assign ser_first = ser_valid && (idx_q == '0);
  assign ser_last  = ser_valid && (idx_q == last_q);
`ifdef BSW_ZERO_SKIP_EN
  assign ser_zero  = ser_valid && zero_q;
`endif

  always_comb begin
    head = mem_q[rd_ptr_q];
    {head_act, head_wgt, head_prec} = head;
    case (head_prec)
      2'd0:    begin head_last = 3'd7; head_mask = 8'hFF; end
      2'd1:    begin head_last = 3'd3; head_mask = 8'h0F; end
      2'd2:    begin head_last = 3'd1; head_mask = 8'h03; end
      default: begin head_last = 3'd0; head_mask = 8'h01; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    last_d  = last_q;
    act_d   = act_q;
`ifdef BSW_ZERO_SKIP_EN
    zero_d  = zero_q;
`endif
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) pop = 1'b1;
      SHIFT: begin
        if (ser_ready) begin
          if (idx_q != last_q) begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Both IDLE and the final beat of SHIFT load through this one path, so chained jobs leave no bubble
    if (pop) begin
      state_d = SHIFT;
      sh_d    = head_wgt;
      idx_d   = '0;
      act_d   = head_act;
      last_d  = head_last;
`ifdef BSW_ZERO_SKIP_EN
      zero_d  = ((head_wgt & head_mask) == 8'h00);
      if (zero_d) last_d = '0;
`endif
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_act, in_wgt, in_prec};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      init_q   <= 1'b0;
      sh_q     <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      act_q    <= '0;
`ifdef BSW_ZERO_SKIP_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      init_q   <= 1'b1;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      act_q    <= act_d;
`ifdef BSW_ZERO_SKIP_EN
      zero_q   <= zero_d;
`endif
    end
  end
endmodule

// File: tb/tb_bitserial_weight_streamer.sv
// Self-checking bench for bitserial_weight_streamer: directed and random jobs against a job-to-beats model.
// Honours BSW_ZERO_SKIP_EN the same way as the design.
module tb_bitserial_weight_streamer;
  localparam int ACT_W = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid, in_ready;
  logic [ACT_W-1:0] in_act;
  logic [7:0]       in_wgt;
  logic [1:0]       in_prec;
  logic             ser_valid, ser_ready, ser_bit, ser_first, ser_last;
  logic [ACT_W-1:0] ser_act;
  logic [2:0]       ser_idx;
  logic             zero_obs;

  always #5 clk = ~clk;

  bitserial_weight_streamer #(.ACT_W(ACT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_prec(in_prec),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
    .ser_act(ser_act), .ser_idx(ser_idx), .ser_first(ser_first), .ser_last(ser_last)
`ifdef BSW_ZERO_SKIP_EN
    , .ser_zero(zero_obs)
`endif
  );
`ifndef BSW_ZERO_SKIP_EN
  assign zero_obs = 1'b0;
`endif

  typedef struct packed {
    logic [ACT_W-1:0] act;
    logic [7:0]       wgt;
    logic [1:0]       prec;
  } job_t;

  typedef struct packed {
    logic             b;
    logic [2:0]       idx;
    logic             first;
    logic             last;
    logic [ACT_W-1:0] act;
    logic             zero;
  } beat_t;

  job_t  pend[$];
  beat_t expq[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference: a job becomes N = 8>>L beats of w[i], LSB first; an all-zero N-bit weight may collapse to one beat.
  function automatic void add_job(input job_t j);
    int n = 8 >> j.prec;
    int w = int'(j.wgt) & ((1 << n) - 1);
    beat_t bt;
`ifdef BSW_ZERO_SKIP_EN
    if (w == 0) begin
      bt.b = 1'b0; bt.idx = 3'd0; bt.first = 1'b1; bt.last = 1'b1; bt.act = j.act; bt.zero = 1'b1;
      expq.push_back(bt);
      return;
    end
`endif
    for (int i = 0; i < n; i++) begin
      bt.b = w[i]; bt.idx = 3'(i); bt.first = (i == 0); bt.last = (i == n - 1);
      bt.act = j.act; bt.zero = 1'b0;
      expq.push_back(bt);
    end
  endfunction

  function automatic beat_t obs();
    beat_t o;
    o.b = ser_bit; o.idx = ser_idx; o.first = ser_first; o.last = ser_last; o.act = ser_act; o.zero = zero_obs;
    return o;
  endfunction

  function automatic job_t mk(input logic [ACT_W-1:0] a, input logic [7:0] w, input logic [1:0] p);
    job_t j;
    j.act = a; j.wgt = w; j.prec = p;
    return j;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    j.act = ACT_W'($urandom); j.wgt = 8'($urandom); j.prec = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 4) == 0) j.wgt = j.wgt & 8'hF0;
    return j;
  endfunction

  // mode 0: always ready, no gaps allowed; 1: random valid/ready; 2: 3-cycle stall at idx 2; 3: ready held low 12 cycles
  task automatic run(input int mode, input string name);
    beat_t prev;
    logic  prev_stall = 1'b0;
    logic  prev_valid = 1'b0;
    logic  seen = 1'b0;
    logic  fire_in, fire_out;
    int    cyc = 0, accepted = 0, stall_left = 3;
    prev = '0;
    while ((pend.size() > 0 || expq.size() > 0) && cyc < 3000) begin
      in_valid = (pend.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
      if (in_valid) {in_act, in_wgt, in_prec} = pend[0];
      else {in_act, in_wgt, in_prec} = ENT_RAND();
      case (mode)
        1: ser_ready = ($urandom_range(0, 2) != 0);
        2: begin
          ser_ready = 1'b1;
          if (ser_valid && ser_idx == 3'd2 && stall_left > 0) begin
            ser_ready = 1'b0;
            stall_left--;
          end
        end
        3: ser_ready = (cyc >= 12);
        default: ser_ready = 1'b1;
      endcase
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({ser_valid, obs()} !== {prev_valid, prev}) begin
          failures++;
          $display("FAIL %s hold: got v=%b %h required v=%b %h", name, ser_valid, obs(), prev_valid, prev);
        end
      end
      if (ser_valid) begin
        checks++;
        seen = 1'b1;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL %s spurious beat: got %h required no beat", name, obs());
        end else if (obs() !== expq[0]) begin
          failures++;
          $display("FAIL %s beat: got %h required %h", name, obs(), expq[0]);
        end
      end else if (mode == 0 && seen && expq.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL %s gap: got ser_valid=0 required 1", name);
      end
      if (mode == 3 && cyc == 12) begin
        checks++;
        if (accepted != DEPTH + 1 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s full: got accepted=%0d in_ready=%b required accepted=%0d in_ready=0",
                   name, accepted, in_ready, DEPTH + 1);
        end
      end
      fire_in    = in_valid && in_ready;
      fire_out   = ser_valid && ser_ready;
      prev       = obs();
      prev_valid = ser_valid;
      prev_stall = ser_valid && !ser_ready;
      @(posedge clk);
      #1;
      if (fire_in) begin
        add_job(pend.pop_front());
        accepted++;
      end
      if (fire_out && expq.size() > 0) void'(expq.pop_front());
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (pend.size() != 0 || expq.size() != 0) begin
      failures++;
      $display("FAIL %s timeout: got %0d jobs %0d beats left required 0", name, pend.size(), expq.size());
    end
    pend.delete();
    expq.delete();
  endtask

  function automatic logic [ACT_W+9:0] ENT_RAND();
    return {ACT_W'($urandom), 8'($urandom), 2'($urandom)};
  endfunction

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
    in_act = '0; in_wgt = '0; in_prec = '0;
    #23;
    checks++;
    if ({in_ready, ser_valid, ser_bit, ser_act, ser_idx, ser_first, ser_last, zero_obs} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got rdy=%b v=%b %h required all 0", in_ready, ser_valid, obs());
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || ser_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset release: got in_ready=%b ser_valid=%b required 1 0", in_ready, ser_valid);
    end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; ser_ready = 1'b1;
    {in_act, in_wgt, in_prec} = mk(8'h5A, 8'h03, 2'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (ser_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency early: got ser_valid=%b required 0", ser_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({ser_valid, ser_first, ser_last, ser_bit, ser_act} !== {4'b1111, 8'h5A}) begin
      failures++;
      $display("FAIL latency beat: got v=%b f=%b l=%b b=%b act=%h required 1 1 1 1 5a",
               ser_valid, ser_first, ser_last, ser_bit, ser_act);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    pend.push_back(mk(8'h3C, 8'hA5, 2'd0));
    run(0, "basic");
  endtask

  task automatic test_short();
    pend.push_back(mk(8'h11, 8'hF6, 2'd2));
    pend.push_back(mk(8'h22, 8'h01, 2'd3));
    run(0, "short");
  endtask

  task automatic test_back_to_back();
    pend.push_back(mk(8'h77, 8'h0B, 2'd1));
    pend.push_back(mk(8'h88, 8'h04, 2'd1));
    pend.push_back(mk(8'h99, 8'h81, 2'd3));
    pend.push_back(mk(8'hAA, 8'h02, 2'd3));
    run(0, "b2b");
  endtask

  task automatic test_stall();
    pend.push_back(mk(8'h3C, 8'hA5, 2'd0));
    run(2, "stall");
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 5; i++) pend.push_back(rand_job());
    pend[0].prec = 2'd0;
    run(3, "full");
  endtask

  task automatic test_zero();
    pend.push_back(mk(8'h42, 8'h00, 2'd0));
    pend.push_back(mk(8'h43, 8'hF0, 2'd1));
    pend.push_back(mk(8'h44, 8'hFE, 2'd3));
    pend.push_back(mk(8'h45, 8'h80, 2'd0));
    run(0, "zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) pend.push_back(rand_job());
    run(1, "random");
  endtask

  task automatic test_reset_mid_job();
    int n = 0;
    ser_ready = 1'b1; in_valid = 1'b1;
    {in_act, in_wgt, in_prec} = mk(8'h3C, 8'hA5, 2'd0);
    @(posedge clk); #1;
    {in_act, in_wgt, in_prec} = mk(8'hC3, 8'h5A, 2'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!(ser_valid && ser_idx == 3'd4) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL midreset reach: got no idx 4 within 50 cycles required idx 4");
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({in_ready, ser_valid, ser_bit, ser_act, ser_idx, ser_first, ser_last, zero_obs} !== '0) begin
      failures++;
      $display("FAIL midreset async: got rdy=%b v=%b %h required all 0", in_ready, ser_valid, obs());
    end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset idle: got ser_valid=%b at cycle %0d required 0", ser_valid, i);
      end
    end
    @(posedge clk); #1;
    pend.push_back(mk(8'h12, 8'h6D, 2'd1));
    run(0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_short();
    test_back_to_back();
    test_stall();
    test_fifo_full();
    test_zero();
    test_random();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
